mem_responder: RTL and testbench

Synthesizable memory-side responder for the CVP14 memory bus: it answers the processor's `Addr`/`RD`/`WR`/`DataIn`/`DataOut` requests. It replaces the behavioural memory model in synthesized system builds.
- Fixed-latency, fully pipelined read path.
- Single-cycle write path.
- Protocol-error detection and access counters.
- Side debug read port, arbitrated against the bus, so a bench or debug host can inspect memory without stopping the core.

---
 rtl/mem_responder.sv | 142 ++++++++++++++
 tb/tb_mem_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: synthesizable memory-side responder for the CVP14 bus.
// Pipelined reads, single-cycle writes, debug side port, error/counters.
module mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LAT     = 2
) (
  input  logic        Clk1,
  input  logic        Reset,
  input  logic [15:0] Addr,
  input  logic        RD,
  input  logic        WR,
  input  logic [15:0] DataIn,
  output logic [15:0] DataOut,
  output logic        DataValid,
  input  logic [15:0] DbgAddr,
  input  logic        DbgRD,
  output logic [15:0] DbgData,
  output logic        DbgValid,
  output logic        DbgBusy,
  output logic        Err,
  output logic [15:0] RdCount,
  output logic [15:0] WrCount
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {D_IDLE, D_PEND} dstate_t;

  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic [DEPTH_LOG2-1:0] dbg_idx;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  illegal;
  logic                  bus_idle;
  logic [RD_LAT-1:0]     pv;
  logic [15:0]           pd [RD_LAT];
  dstate_t               dstate;
  dstate_t               dstate_nx;
  logic                  dbg_take;
  logic                  dbg_fire;
  logic                  unused_hi;

  assign idx       = Addr[DEPTH_LOG2-1:0];
  assign rd_acc    = RD & ~WR;
  assign wr_acc    = WR & ~RD;
  assign illegal   = RD & WR;
  assign bus_idle  = ~RD & ~WR;
  assign unused_hi = ^{Addr, DbgAddr};

  // array write; contents survive reset, but a write under reset is dropped
  always_ff @(posedge Clk1) begin
    if (!Reset && wr_acc)
      mem[idx] <= DataIn;
  end

  // read pipeline; each data stage loads only behind a valid, so the
  // last stage holds the previous result while DataValid is low
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      pv <= '0;
      for (int i = 0; i < RD_LAT; i++)
        pd[i] <= '0;
    end else begin
      pv[0] <= rd_acc;
      if (rd_acc)
        pd[0] <= mem[idx];
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1])
          pd[i] <= pd[i-1];
      end
    end
  end

  assign DataValid = pv[RD_LAT-1];
  assign DataOut   = pd[RD_LAT-1];

  // debug FSM state register
  always_ff @(posedge Clk1) begin
    if (Reset)
      dstate <= D_IDLE;
    else
      dstate <= dstate_nx;
  end

  // debug next state: bus always wins, debug fires only on idle bus
  always_comb begin
    dstate_nx = dstate;
    dbg_take  = 1'b0;
    dbg_fire  = 1'b0;
    unique case (dstate)
      D_IDLE: begin
        if (DbgRD) begin
          dbg_take  = 1'b1;
          dstate_nx = D_PEND;
        end
      end
      D_PEND: begin
        if (bus_idle) begin
          dbg_fire  = 1'b1;
          dstate_nx = D_IDLE;
        end
      end
      default: dstate_nx = D_IDLE;
    endcase
  end

  assign DbgBusy = (dstate == D_PEND);

  // debug address latch and registered debug result
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      dbg_idx  <= '0;
      DbgData  <= '0;
      DbgValid <= 1'b0;
    end else begin
      if (dbg_take)
        dbg_idx <= DbgAddr[DEPTH_LOG2-1:0];
      DbgValid <= dbg_fire;
      if (dbg_fire)
        DbgData <= mem[dbg_idx];
    end
  end

  // sticky error flag and saturating access counters
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      Err     <= 1'b0;
      RdCount <= '0;
      WrCount <= '0;
    end else begin
      if (illegal)
        Err <= 1'b1;
      if (rd_acc && RdCount != 16'hFFFF)
        RdCount <= RdCount + 16'd1;
      if (wr_acc && WrCount != 16'hFFFF)
        WrCount <= WrCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder with a queue-based
// reference model compared on every cycle plus literal spot checks.
module tb_mem_responder;

  localparam int RD_LAT = 2;

  logic        Clk1;
  logic        Reset;
  logic [15:0] Addr;
  logic        RD;
  logic        WR;
  logic [15:0] DataIn;
  logic [15:0] DataOut;
  logic        DataValid;
  logic [15:0] DbgAddr;
  logic        DbgRD;
  logic [15:0] DbgData;
  logic        DbgValid;
  logic        DbgBusy;
  logic        Err;
  logic [15:0] RdCount;
  logic [15:0] WrCount;

  int total = 0;
  int bad   = 0;

  mem_responder #(.DEPTH_LOG2(10), .RD_LAT(RD_LAT)) dut (
    .Clk1(Clk1), .Reset(Reset), .Addr(Addr), .RD(RD), .WR(WR),
    .DataIn(DataIn), .DataOut(DataOut), .DataValid(DataValid),
    .DbgAddr(DbgAddr), .DbgRD(DbgRD), .DbgData(DbgData),
    .DbgValid(DbgValid), .DbgBusy(DbgBusy), .Err(Err),
    .RdCount(RdCount), .WrCount(WrCount)
  );

  initial Clk1 = 1'b0;
  always #5 Clk1 = ~Clk1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: word array plus a queue of reads with due edges
  typedef struct {
    int          due;
    logic [15:0] data;
  } rd_t;

  logic [15:0] mdl [1024];
  rd_t         q [$];
  int          ecyc = 0;
  bit          live = 0;
  bit          pend = 0;
  logic [9:0]  daddr = '0;
  logic        e_dv, e_dbv, e_busy, e_err;
  logic [15:0] e_do, e_dbd;
  int          e_rc, e_wc;

  always @(posedge Clk1) begin
    ecyc++;
    if (Reset) begin
      q.delete();
      e_dv = 0; e_do = 0; e_dbv = 0; e_dbd = 0;
      e_busy = 0; e_err = 0; e_rc = 0; e_wc = 0;
      pend = 0;
      live = 1;
    end else begin
      e_dbv = 0;
      if (pend && !RD && !WR) begin
        e_dbd = mdl[daddr];
        e_dbv = 1;
        pend  = 0;
      end else if (!pend && DbgRD) begin
        pend  = 1;
        daddr = DbgAddr[9:0];
      end
      if (RD && WR) begin
        e_err = 1;
      end else if (RD) begin
        q.push_back('{due: ecyc + RD_LAT - 1, data: mdl[Addr[9:0]]});
        if (e_rc < 65535) e_rc++;
      end else if (WR) begin
        mdl[Addr[9:0]] = DataIn;
        if (e_wc < 65535) e_wc++;
      end
      e_dv = 0;
      if (q.size() > 0 && q[0].due == ecyc) begin
        e_dv = 1;
        e_do = q[0].data;
        void'(q.pop_front());
      end
      e_busy = pend;
    end
  end

  // per-cycle comparison against the model
  always @(negedge Clk1) begin
    if (live) begin
      chk("m_dv", DataValid, e_dv);
      chk("m_do", DataOut, e_do);
      chk("m_dbv", DbgValid, e_dbv);
      chk("m_dbd", DbgData, e_dbd);
      chk("m_busy", DbgBusy, e_busy);
      chk("m_err", Err, e_err);
      chk("m_rc", RdCount, e_rc[15:0]);
      chk("m_wc", WrCount, e_wc[15:0]);
    end
  end

  task automatic bus(input logic r, input logic w,
                     input logic [15:0] a, input logic [15:0] d);
    RD = r; WR = w; Addr = a; DataIn = d;
  endtask

  task automatic tick();
    @(posedge Clk1);
    #1;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_do"}, DataOut, 16'h0);
    chk({nm, "_dv"}, DataValid, 1'b0);
    chk({nm, "_dbd"}, DbgData, 16'h0);
    chk({nm, "_dbv"}, DbgValid, 1'b0);
    chk({nm, "_busy"}, DbgBusy, 1'b0);
    chk({nm, "_err"}, Err, 1'b0);
    chk({nm, "_rc"}, RdCount, 16'h0);
    chk({nm, "_wc"}, WrCount, 16'h0);
  endtask

  initial begin
    Reset = 1; DbgAddr = 0; DbgRD = 0;
    bus(0, 0, 16'h0, 16'h0);
    tick(); tick();
    Reset = 0;
    chk_reset_vals("rst");

    // write then read back
    bus(0, 1, 16'h0010, 16'hBEEF); tick();
    bus(1, 0, 16'h0010, 16'h0); tick();
    chk("t1_early", DataValid, 1'b0);
    bus(0, 0, 16'h0, 16'h0); tick();
    chk("t1_dv", DataValid, 1'b1);
    chk("t1_do", DataOut, 16'hBEEF);
    chk("t1_wc", WrCount, 16'd1);
    chk("t1_rc", RdCount, 16'd1);
    tick();
    chk("t1_pulse", DataValid, 1'b0);
    chk("t1_hold", DataOut, 16'hBEEF);

    // fill then back-to-back reads
    for (int i = 0; i < 8; i++) begin
      bus(0, 1, 16'(i), 16'h1000 + 16'(i)); tick();
    end
    for (int j = 0; j < 10; j++) begin
      if (j < 8) bus(1, 0, 16'(j), 16'h0);
      else bus(0, 0, 16'h0, 16'h0);
      tick();
      if (j >= 1 && j <= 8) begin
        chk("t2_dv", DataValid, 1'b1);
        chk("t2_do", DataOut, 16'h1000 + 16'(j - 1));
      end
    end
    chk("t2_rc", RdCount, 16'd9);
    chk("t2_wc", WrCount, 16'd9);

    // aliasing and read-before-write
    bus(0, 1, 16'h0005, 16'hAAAA); tick();
    bus(0, 1, 16'h0405, 16'h5555); tick();
    bus(1, 0, 16'h0005, 16'h0); tick();
    bus(0, 0, 16'h0, 16'h0); tick();
    chk("t3_alias", DataOut, 16'h5555);
    bus(1, 0, 16'h0005, 16'h0); tick();
    bus(0, 1, 16'h0005, 16'h1234); tick();
    chk("t3_rbw_dv", DataValid, 1'b1);
    chk("t3_rbw", DataOut, 16'h5555);
    bus(1, 0, 16'h0005, 16'h0); tick();
    bus(0, 0, 16'h0, 16'h0); tick();
    chk("t3_new", DataOut, 16'h1234);

    // illegal command
    bus(0, 1, 16'h0020, 16'h0000); tick();
    bus(1, 1, 16'h0020, 16'hFFFF); tick();
    chk("t4_err", Err, 1'b1);
    chk("t4_rc", RdCount, 16'd12);
    chk("t4_wc", WrCount, 16'd13);
    bus(0, 0, 16'h0, 16'h0); tick(); tick();
    chk("t4_sticky", Err, 1'b1);
    bus(1, 0, 16'h0020, 16'h0); tick();
    bus(0, 0, 16'h0, 16'h0); tick();
    chk("t4_dv", DataValid, 1'b1);
    chk("t4_mem", DataOut, 16'h0000);

    // debug read starved by three bus reads
    DbgAddr = 16'h0010; DbgRD = 1;
    bus(1, 0, 16'h0000, 16'h0); tick();
    DbgRD = 0;
    chk("t5_busy1", DbgBusy, 1'b1);
    bus(1, 0, 16'h0001, 16'h0); tick();
    chk("t5_busy2", DbgBusy, 1'b1);
    chk("t5_do0", DataOut, 16'h1000);
    bus(1, 0, 16'h0002, 16'h0); tick();
    chk("t5_busy3", DbgBusy, 1'b1);
    chk("t5_dbv0", DbgValid, 1'b0);
    chk("t5_do1", DataOut, 16'h1001);
    bus(0, 0, 16'h0, 16'h0); tick();
    chk("t5_dbv", DbgValid, 1'b1);
    chk("t5_dbd", DbgData, 16'hBEEF);
    chk("t5_busy0", DbgBusy, 1'b0);
    chk("t5_do2", DataOut, 16'h1002);
    tick();
    chk("t5_dbv_end", DbgValid, 1'b0);

    // reset with reads in flight, pending debug and a write
    DbgAddr = 16'h0005; DbgRD = 1;
    bus(1, 0, 16'h0001, 16'h0); tick();
    DbgRD = 0;
    bus(1, 0, 16'h0002, 16'h0); tick();
    chk("t6_busy", DbgBusy, 1'b1);
    Reset = 1;
    bus(0, 1, 16'h0010, 16'h0000); tick();
    Reset = 0;
    chk_reset_vals("t6");
    bus(0, 0, 16'h0, 16'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t6_no_dv", DataValid, 1'b0);
      chk("t6_no_dbv", DbgValid, 1'b0);
    end
    bus(1, 0, 16'h0010, 16'h0); tick();
    bus(0, 0, 16'h0, 16'h0); tick();
    chk("t6_kept", DataOut, 16'hBEEF);

    // write counter saturation
    for (int n = 0; n < 65540; n++) begin
      bus(0, 1, 16'h03FF, 16'(n)); tick();
    end
    bus(0, 0, 16'h0, 16'h0); tick();
    chk("t7_wc_sat", WrCount, 16'hFFFF);
    chk("t7_rc", RdCount, 16'd1);
    chk("t7_err", Err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
